// File: rtl/fsm.sv
`default_nettype none
// ============================================================================
//  Module      : fsm
//  Description : Serial "0110" sequence detector (Moore machine).
//                One input bit is sampled on every rising edge of Clk.
//                Overlapping matches are detected: the trailing '0' of a
//                match also counts as the first '0' of the next match.
//                outp is high for exactly one cycle, in the cycle after the
//                edge that samples the final '0' of a match.
//  Ports       : Clk   in  1  system clock, rising-edge active
//                reset in  1  synchronous reset, active low
//                in    in  1  serial data bit
//                outp  out 1  detect flag, one-cycle pulse per match
//  Revision    : 1.0  initial release
// ============================================================================
module fsm (
   input  logic Clk,
   input  logic reset,
   input  logic in,
   output logic outp
);

   // Each state names the longest useful suffix of the bits seen so far.
   typedef enum logic [2:0] {
      S0 = 3'd0,   // no useful prefix
      S1 = 3'd1,   // suffix "0"
      S2 = 3'd2,   // suffix "01"
      S3 = 3'd3,   // suffix "011"
      S4 = 3'd4    // "0110" just completed
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_outp;

   // State register. Reset overrides the data input, so a partial prefix is
   // discarded and any bit sampled while reset is low is ignored.
   always_ff @(posedge Clk) begin
      if (!reset) begin
         r_state <= S0;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      w_next = S0;
      w_outp = 1'b0;
      case (r_state)
         S0: begin
            w_next = in ? S0 : S1;
         end
         S1: begin
            w_next = in ? S2 : S1;
         end
         S2: begin
            w_next = in ? S3 : S1;
         end
         S3: begin
            w_next = in ? S0 : S4;
         end
         S4: begin
            w_outp = 1'b1;
            // Trailing '0' of this match is the leading '0' of the next.
            w_next = in ? S2 : S1;
         end
         default: begin
            // Illegal encodings recover to idle with the flag low.
            w_next = S0;
            w_outp = 1'b0;
         end
      endcase
   end

   // Output depends on the state register only, never directly on in.
   assign outp = w_outp;

endmodule
`default_nettype wire

// File: tb/tb_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm
//  Description : Self-checking bench for the "0110" sequence detector.
//                Vector records hold {reset, in, expected outp}; the
//                expected value is queued when a vector is driven and popped
//                when outp is sampled after the clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fsm;

   logic clk;
   logic rst_n;
   logic din;
   logic dout;

   int   n_checks;
   int   n_fail;

   typedef struct packed {
      logic rst_n;
      logic din;
      logic exp;
   } vec_t;

   vec_t vecs[$];
   logic exp_q[$];

   fsm dut (
      .Clk   (clk),
      .reset (rst_n),
      .in    (din),
      .outp  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one bit away from the active edge, queue its expected result,
   // then sample outp shortly after the edge and compare.
   task automatic step(input logic r, input logic d, input logic e, input string name);
      logic exp_v;
      @(negedge clk);
      rst_n = r;
      din   = d;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, outp=%0b", name, dout);
      end else begin
         exp_v = exp_q.pop_front();
         if (dout !== exp_v) begin
            n_fail++;
            $display("FAIL %s: outp=%0b expected %0b (t=%0t)", name, dout, exp_v, $time);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      din      = 1'b0;

      // Test 1: reset for two edges with arbitrary data.
      vecs.push_back('{1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0});
      // Test 2: 0,1,1,0 -> pulse after 4th bit, then low again.
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b0});
      // Test 3: 0,1,0,1,1,0,0 -> single pulse after 6th bit.
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0});
      // Test 4: overlap 0,1,1,0,1,1,0 -> pulses after bits 4 and 7.
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b0});
      // Test 6a: 1,1,1,1,0,0,1,0 -> never high.
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst_n, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Test 6b: from S1 (last bit was 0), 1,1,0 reaches S4, then reset
      // while in S4 must clear the flag despite in=1.
      step(1'b1, 1'b1, 1'b0, "s4_prep1");
      step(1'b1, 1'b1, 1'b0, "s4_prep2");
      step(1'b1, 1'b0, 1'b1, "s4_reach");
      step(1'b0, 1'b1, 1'b0, "s4_reset");
      step(1'b1, 1'b1, 1'b0, "s4_after");

      // Test 5: partial 0,1,1 then reset with in=0 (would have matched),
      // then 0 -> no pulse; follow with 1,1,0 -> pulse.
      step(1'b0, 1'b1, 1'b0, "mid_init");
      step(1'b1, 1'b0, 1'b0, "mid_b0");
      step(1'b1, 1'b1, 1'b0, "mid_b1");
      step(1'b1, 1'b1, 1'b0, "mid_b2");
      step(1'b0, 1'b0, 1'b0, "mid_reset");
      step(1'b1, 1'b0, 1'b0, "mid_restart0");
      step(1'b1, 1'b1, 1'b0, "mid_r1");
      step(1'b1, 1'b1, 1'b0, "mid_r2");
      step(1'b1, 1'b0, 1'b1, "mid_match");
      step(1'b1, 1'b0, 1'b0, "mid_pulse_end");

      // Random data while reset is held low must not disturb idle.
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'($urandom_range(1, 0)), 1'b0, $sformatf("rst_hold%0d", k));
      end
      // From idle, 1,1,0 alone is not a match.
      step(1'b1, 1'b1, 1'b0, "idle_1a");
      step(1'b1, 1'b1, 1'b0, "idle_1b");
      step(1'b1, 1'b0, 1'b0, "idle_0");

      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
